// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared types and constants for the RISC-V instruction fetch path.
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_ADDR = 2'd1,
    IF_DATA = 2'd2,
    IF_RESP = 2'd3
  } if_fetch_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0]  AXI_ARPROT_INSTR = 3'b100;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/riscv_if_instr_lane_sel.sv
`default_nettype none
// ============================================================================
// Module  : riscv_if_instr_lane_sel
// Purpose : Picks the 32-bit instruction lane out of an AXI-Lite read beat.
// Rev     : 1.0  initial release
// ============================================================================
module riscv_if_instr_lane_sel #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  pc_bit2,
  output logic [31:0]           instr
);

  if (DATA_WIDTH == 64) begin : g_dw64
    assign instr = pc_bit2 ? rdata[63:32] : rdata[31:0];
  end else begin : g_dw32
    // A 32-bit bus carries exactly one instruction, so the PC bit is irrelevant.
    logic unused_pc_bit2;
    assign unused_pc_bit2 = pc_bit2;
    assign instr          = rdata[31:0];
  end

endmodule
`default_nettype wire

// File: rtl/riscv_if_instr_fetch_axil.sv
`default_nettype none
// ============================================================================
// Module  : riscv_if_instr_fetch_axil
// Purpose : Single-outstanding AXI-Lite instruction fetcher with PC stall.
//           Optional macro RISCV_IF_FETCH_ERR_TRAP_EN reports bus errors.
// Rev     : 1.0  initial release
// ============================================================================
module riscv_if_instr_fetch_axil
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_hold,
  output logic                  o_stall,
  output logic [31:0]           o_instr,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr_pc,
  output logic                  o_fetch_err,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] ST_IDLE = IF_IDLE;
  localparam logic [1:0] ST_ADDR = IF_ADDR;
  localparam logic [1:0] ST_DATA = IF_DATA;
  localparam logic [1:0] ST_RESP = IF_RESP;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ADDR_WIDTH-1:0] araddr_d;
  logic [31:0]           instr_q;
  logic [31:0]           lane_instr;
  logic                  err_q;
  logic                  fetch_err_d;

  // Bus-aligned address: the beat always covers the whole data word.
  assign araddr_d = {i_pc[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

  if (ADDR_WIDTH < DATA_WIDTH) begin : g_pc_hi_unused
    logic unused_pc_hi;
    assign unused_pc_hi = ^i_pc[DATA_WIDTH-1:ADDR_WIDTH];
  end

`ifdef RISCV_IF_FETCH_ERR_TRAP_EN
  assign fetch_err_d = (m_rresp != AXI_RESP_OKAY);
`else
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;
  assign fetch_err_d  = 1'b0;
`endif

  riscv_if_instr_lane_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_sel (
    .rdata   (m_rdata),
    .pc_bit2 (pc_q[2]),
    .instr   (lane_instr)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      pc_q     <= '0;
      araddr_q <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            pc_q     <= i_pc;
            araddr_q <= araddr_d;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_rvalid) begin
            instr_q <= fetch_err_d ? RV_NOP : lane_instr;
            err_q   <= fetch_err_d;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!i_hold) begin
            err_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall is a decode of registered state and i_hold only, never of i_pc.
  assign o_stall       = !((state == ST_RESP) && !i_hold);
  assign o_instr_valid = (state == ST_RESP);
  assign o_instr       = instr_q;
  assign o_instr_pc    = pc_q;
  assign o_fetch_err   = err_q;
  assign m_araddr      = araddr_q;
  assign m_arprot      = AXI_ARPROT_INSTR;
  assign m_arvalid     = (state == ST_ADDR);
  assign m_rready      = (state == ST_DATA);

endmodule
`default_nettype wire
